// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller state encoding and a counter-width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to count 0..n-1; never returns less than 1 so the counter
    // always has a legal width.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built from chained full-adder cells.
module ripple_adder #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin
);

    logic carry;

    // Full-adder chain, LSB first; carry ripples cell to cell.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add multiplier controller. One shared ripple adder is
// reused for WIDTH steps; product is registered and held until the next
// accepted operation completes.
// Build option: EARLY_TERM_EN finishes as soon as the remaining multiplier
// bits are all zero, collapsing the trailing shifts into one edge.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for start
//   ST_RUN  | one add/shift step per edge, busy high
//   ST_DONE | product valid, done pulse; start re-accepted
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int                CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     add_y;
    logic [WIDTH-1:0]     add_s;
    logic                 add_c;
    logic [2*WIDTH-1:0]   p_step;
    logic [2*WIDTH-1:0]   p_next;
    logic                 last_step;
    logic                 accept;

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign add_y  = p_q[0] ? mcand_q : '0;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .sum  (add_s),
        .cout (add_c),
        .x    (p_q[2*WIDTH-1:WIDTH]),
        .y    (add_y),
        .cin  (1'b0)
    );

    // Carry goes into the top bit so the 2W+1-bit intermediate is never lost.
    assign p_step = {add_c, add_s, p_q[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic             early;

    // Multiplier bits still waiting behind the one consumed this edge.
    assign rem_mask  = {WIDTH{1'b1}} >> cnt_q >> 1;
    assign early     = ~|((p_q[WIDTH-1:0] >> 1) & rem_mask);
    assign p_next    = early ? (p_step >> (CNT_LAST - cnt_q)) : p_step;
    assign last_step = early || (cnt_q == CNT_LAST);
`else
    assign p_next    = p_step;
    assign last_step = (cnt_q == CNT_LAST);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_RUN;
            ST_RUN:  if (last_step) state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Operand capture, add/shift datapath and product register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand_q <= a;
            p_q     <= {{WIDTH{1'b0}}, b};
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            p_q <= p_next;
            if (last_step) begin
                product_q <= p_next;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl at WIDTH=4.
module tb_shift_add_mult_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_checks;
    int n_fail;

    shift_add_mult_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RUN edges expected for a given multiplier value.
    function automatic int exp_edges(input logic [3:0] mb);
        int e;
`ifdef EARLY_TERM_EN
        e = 1;
        for (int i = 0; i < 4; i++) begin
            if (mb[i]) e = i + 1;
        end
`else
        e = 4;
`endif
        return e;
    endfunction

    // Wait for done, counting RUN edges; bounded so a stuck DUT still ends.
    task automatic wait_done(input int n_start, output int n);
        n = n_start;
        while (!done && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input string tag, output int n);
        logic [7:0] exp_p;
        exp_p = 8'(ia) * 8'(ib);
        a = ia;
        b = ib;
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq({tag, " busy after accept"}, 32'(busy), 32'd1);
        wait_done(0, n);
        check_eq({tag, " run edges"}, n, exp_edges(ib));
        check_eq({tag, " done"}, 32'(done), 32'd1);
        check_eq({tag, " busy in done"}, 32'(busy), 32'd0);
        check_eq({tag, " product"}, 32'(product), 32'(exp_p));
        step();
        check_eq({tag, " done one cycle"}, 32'(done), 32'd0);
        check_eq({tag, " product held"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;

        // T1 reset
        step();
        step();
        check_eq("T1 busy", 32'(busy), 32'd0);
        check_eq("T1 done", 32'(done), 32'd0);
        check_eq("T1 product", 32'(product), 32'h00);
        rst_n = 1'b1;
        step();

        // T2 15*15
        run_op(4'd15, 4'd15, "T2", n);
        step();
        step();
        check_eq("T2 product later", 32'(product), 32'hE1);
        check_eq("T2 idle", 32'(busy), 32'd0);

        // T3 start mid-RUN ignored
        a = 4'd13;
        b = 4'd11;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 4'd1;
        b = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        check_eq("T3 still busy", 32'(busy), 32'd1);
        wait_done(2, n);
        check_eq("T3 run edges", n, 32'd4);
        check_eq("T3 product", 32'(product), 32'h8F);
        step();
        check_eq("T3 no queued op", 32'(busy), 32'd0);
        step();
        check_eq("T3 no second done", 32'(done), 32'd0);
        check_eq("T3 product held", 32'(product), 32'h8F);

        // T4 reset mid-RUN
        a = 4'd9;
        b = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check_eq("T4 busy after reset", 32'(busy), 32'd0);
        check_eq("T4 done after reset", 32'(done), 32'd0);
        check_eq("T4 product cleared", 32'(product), 32'h00);
        rst_n = 1'b1;
        step();
        step();
        step();
        check_eq("T4 no late done", 32'(done), 32'd0);
        check_eq("T4 stays idle", 32'(busy), 32'd0);
        run_op(4'd9, 4'd7, "T4 rerun", n);
        check_eq("T4 rerun product", 32'(product), 32'h3F);

        // T5 back-to-back with start held
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        step();
        wait_done(0, n);
        check_eq("T5 first edges", n, exp_edges(4'd5));
        check_eq("T5 first done", 32'(done), 32'd1);
        check_eq("T5 first product", 32'(product), 32'h0F);
        step();
        start = 1'b0;
        check_eq("T5 re-accepted", 32'(busy), 32'd1);
        check_eq("T5 done dropped", 32'(done), 32'd0);
        wait_done(0, n);
        check_eq("T5 second edges", n, exp_edges(4'd5));
        check_eq("T5 second done", 32'(done), 32'd1);
        check_eq("T5 second product", 32'(product), 32'h0F);
        step();

`ifdef EARLY_TERM_EN
        run_op(4'd7, 4'd1, "T6 b1", n);
        check_eq("T6 b=1 one RUN edge", n, 32'd1);
`endif

        // T6 exhaustive
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op(4'(ai), 4'(bi), $sformatf("T6 %0d*%0d", ai, bi), n);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
